// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with flush/branch redirect
// and capture of a branch that arrives while fetch is stalled.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             stall bus; only bit 0 holds the PC
//   flush_i/flush_pc_i  flush redirect (highest priority)
//   br_valid_i/br_target_i  taken branch or jump from EX
//   pc_o, ce_o        fetch address and fetch enable
//   pend_o            a branch is captured, waiting for stall release
//   misalign_o        one-cycle pulse on a misaligned redirect
//   bad_addr_o        last misaligned redirect target
//
// Build option: PC_MISALIGN_TRAP_EN
//   defined:   misaligned redirects go to TRAP_VEC and are reported
//   undefined: low ALIGN_BITS of every redirect target are cleared;
//              misalign_o and bad_addr_o are constant 0
module pc_gen #(
  parameter int unsigned              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]        RESET_VEC  = 32'h0000_0000,
  parameter int unsigned              STEP       = 4,
  parameter int unsigned              STALL_W    = 6,
  parameter int unsigned              ALIGN_BITS = 2,
  parameter logic [ADDR_W-1:0]        TRAP_VEC   = 32'h0000_0004
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  flush_pc_i,
  input  logic               br_valid_i,
  input  logic [ADDR_W-1:0]  br_target_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               ce_o,
  output logic               pend_o,
  output logic               misalign_o,
  output logic [ADDR_W-1:0]  bad_addr_o
);

  typedef enum logic [1:0] {
    S_OFF,
    S_RUN,
    S_PEND
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    {ADDR_W{1'b1}} << ALIGN_BITS;
  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pend_pc;
  logic              r_ce;

  logic              w_hold;
  logic              w_redir;
  logic              w_capture;
  logic [ADDR_W-1:0] w_raw;
  logic [ADDR_W-1:0] w_fixed;
  logic              w_bad;

  // Upper stall bits carry other stages' stalls; fetch ignores them.
  logic w_stall_unused;
  assign w_stall_unused = &{1'b0, stall[STALL_W-1:1]};

  assign w_hold = stall[0];

  // Redirect source selection in priority order. A redirect loads
  // w_raw into the PC; a capture parks the branch target instead.
  always_comb begin
    w_redir   = 1'b0;
    w_capture = 1'b0;
    w_raw     = r_pend_pc;
    if (flush_i) begin
      w_redir = 1'b1;
      w_raw   = flush_pc_i;
    end else if (br_valid_i && !w_hold) begin
      w_redir = 1'b1;
      w_raw   = br_target_i;
    end else if (br_valid_i) begin
      w_capture = 1'b1;
    end else if (r_state == S_PEND && !w_hold) begin
      w_redir = 1'b1;
      w_raw   = r_pend_pc;
    end
  end

  assign w_bad   = |(w_raw & ~ALIGN_MASK);
  assign w_fixed = w_raw & ALIGN_MASK;

`ifdef PC_MISALIGN_TRAP_EN
  logic              r_misalign;
  logic [ADDR_W-1:0] r_bad_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
      r_bad_addr <= '0;
    end else begin
      r_misalign <= 1'b0;
      if (r_state != S_OFF && w_redir && w_bad) begin
        r_misalign <= 1'b1;
        r_bad_addr <= w_raw;
      end
    end
  end

  assign misalign_o = r_misalign;
  assign bad_addr_o = r_bad_addr;
`else
  logic w_align_unused;
  assign w_align_unused = &{1'b0, w_bad, TRAP_VEC};

  assign misalign_o = 1'b0;
  assign bad_addr_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_OFF;
      r_pc      <= RESET_VEC;
      r_ce      <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      unique case (r_state)
        S_OFF: begin
          // PC stays at the reset vector so it is fetched first.
          r_state <= S_RUN;
          r_ce    <= 1'b1;
        end
        default: begin
          if (w_redir) begin
            r_state   <= S_RUN;
            r_pend_pc <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            r_pc      <= w_bad ? TRAP_VEC : w_raw;
`else
            r_pc      <= w_fixed;
`endif
          end else if (w_capture) begin
            // A newer branch replaces an older parked one.
            r_state   <= S_PEND;
            r_pend_pc <= br_target_i;
          end else if (r_state == S_RUN && !w_hold) begin
            r_pc <= r_pc + STEP_V;
          end
        end
      endcase
    end
  end

  assign pc_o   = r_pc;
  assign ce_o   = r_ce;
  assign pend_o = (r_state == S_PEND);

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen
// hand-computed expected PC sequences
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        br_valid_i;
  logic [31:0] br_target_i;
  logic [31:0] pc_o;
  logic        ce_o;
  logic        pend_o;
  logic        misalign_o;
  logic [31:0] bad_addr_o;

  int n_chk = 0;
  int n_err = 0;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_PC   = 32'h4;
  localparam logic [31:0] MIS_NEXT = 32'h8;
  localparam logic [31:0] MIS_FLG  = 32'h1;
  localparam logic [31:0] MIS_BAD  = 32'h102;
  localparam logic [31:0] FL_PC    = 32'h4;
`else
  localparam logic [31:0] MIS_PC   = 32'h100;
  localparam logic [31:0] MIS_NEXT = 32'h104;
  localparam logic [31:0] MIS_FLG  = 32'h0;
  localparam logic [31:0] MIS_BAD  = 32'h0;
  localparam logic [31:0] FL_PC    = 32'h80;
`endif

  always #5 clk = ~clk;

  pc_gen dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush_i    (flush_i),
    .flush_pc_i (flush_pc_i),
    .br_valid_i (br_valid_i),
    .br_target_i(br_target_i),
    .pc_o       (pc_o),
    .ce_o       (ce_o),
    .pend_o     (pend_o),
    .misalign_o (misalign_o),
    .bad_addr_o (bad_addr_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall       = 6'b0;
    flush_i     = 1'b0;
    flush_pc_i  = 32'h0;
    br_valid_i  = 1'b0;
    br_target_i = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) tick();
    check("rst_ce", 32'(ce_o), 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_pend", 32'(pend_o), 32'h0);
    check("rst_mis", 32'(misalign_o), 32'h0);
    check("rst_bad", bad_addr_o, 32'h0);

    rst = 1'b0;
    tick();
    check("rel_ce", 32'(ce_o), 32'h1);
    check("rel_pc0", pc_o, 32'h0);
    tick();
    check("rel_pc4", pc_o, 32'h4);
    tick();
    check("rel_pc8", pc_o, 32'h8);

    stall = 6'b000001;
    tick();
    check("stall_1", pc_o, 32'h8);
    tick();
    check("stall_2", pc_o, 32'h8);
    stall = 6'b0;
    tick();
    check("stall_rel", pc_o, 32'hC);
    stall = 6'b111110;
    tick();
    check("stall_hi_ign", pc_o, 32'h10);

    stall       = 6'b000001;
    br_valid_i  = 1'b1;
    br_target_i = 32'h100;
    tick();
    check("cap1_pend", 32'(pend_o), 32'h1);
    check("cap1_pc", pc_o, 32'h10);
    br_target_i = 32'h200;
    tick();
    check("cap2_pend", 32'(pend_o), 32'h1);
    check("cap2_pc", pc_o, 32'h10);
    br_valid_i = 1'b0;
    tick();
    check("cap_hold", pc_o, 32'h10);
    stall = 6'b0;
    tick();
    check("cap_apply", pc_o, 32'h200);
    check("cap_pend0", 32'(pend_o), 32'h0);
    tick();
    check("cap_next", pc_o, 32'h204);

    stall       = 6'b000001;
    flush_i     = 1'b1;
    flush_pc_i  = 32'h80;
    br_valid_i  = 1'b1;
    br_target_i = 32'h100;
    tick();
    check("fl_pc", pc_o, 32'h80);
    check("fl_pend", 32'(pend_o), 32'h0);
    flush_i    = 1'b0;
    br_valid_i = 1'b0;
    tick();
    check("fl_hold", pc_o, 32'h80);
    stall = 6'b0;
    tick();
    check("fl_next", pc_o, 32'h84);

    stall       = 6'b000001;
    br_valid_i  = 1'b1;
    br_target_i = 32'h300;
    tick();
    check("new_pend", 32'(pend_o), 32'h1);
    stall       = 6'b0;
    br_target_i = 32'h400;
    tick();
    check("new_wins", pc_o, 32'h400);
    check("new_pend0", 32'(pend_o), 32'h0);
    br_valid_i = 1'b0;
    tick();
    check("new_next", pc_o, 32'h404);

    flush_i    = 1'b1;
    flush_pc_i = 32'hFFFF_FFFC;
    tick();
    flush_i = 1'b0;
    check("wrap_top", pc_o, 32'hFFFF_FFFC);
    tick();
    check("wrap_zero", pc_o, 32'h0);

    br_valid_i  = 1'b1;
    br_target_i = 32'h102;
    tick();
    br_valid_i = 1'b0;
    check("mis_pc", pc_o, MIS_PC);
    check("mis_flag", 32'(misalign_o), MIS_FLG);
    check("mis_bad", bad_addr_o, MIS_BAD);
    tick();
    check("mis_pulse", 32'(misalign_o), 32'h0);
    check("mis_next", pc_o, MIS_NEXT);

    flush_i    = 1'b1;
    flush_pc_i = 32'h83;
    tick();
    flush_i = 1'b0;
    check("fl_mis_pc", pc_o, FL_PC);

    stall       = 6'b000001;
    br_valid_i  = 1'b1;
    br_target_i = 32'h500;
    tick();
    check("rp_pend", 32'(pend_o), 32'h1);
    br_valid_i = 1'b0;
    rst        = 1'b1;
    tick();
    check("rp_pend0", 32'(pend_o), 32'h0);
    check("rp_pc", pc_o, 32'h0);
    check("rp_ce", 32'(ce_o), 32'h0);
    rst   = 1'b0;
    stall = 6'b0;
    tick();
    check("rp_rel_pc", pc_o, 32'h0);
    check("rp_rel_ce", 32'(ce_o), 32'h1);
    tick();
    check("rp_no_tgt", pc_o, 32'h4);
    check("rp_no_pend", 32'(pend_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage, successor to the fixed 32-bit increment-only PC register. Adds a configurable reset vector and step, flush and branch redirects with fixed priority, and capture of a branch that arrives while fetch is stalled. Sits at the head of the pipeline. Drives `pc_o` and `ce_o` to instruction memory and the IF/ID register. Receives `stall` from the stall controller, branch resolution from EX, and flush from the exception/commit logic.

## Interface
- `ADDR_W`, 32: PC width.
- `RESET_VEC`, 32'h0000_0000: PC value after reset.
- `STEP`, 4: sequential increment in bytes.
- `STALL_W`, 6: stall bus width; only bit 0 is consumed.
- `ALIGN_BITS`, 2: number of low target bits that must be zero.
- `TRAP_VEC`, 32'h0000_0004: misalignment trap target; used only with the macro.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `stall` input STALL_W: bit 0 = 1 holds the PC.
- `flush_i` input 1: flush redirect request, highest priority.
- `flush_pc_i` input ADDR_W: flush target.
- `br_valid_i` input 1: taken branch or jump from EX.
- `br_target_i` input ADDR_W: branch target.
- `pc_o` output ADDR_W: current fetch address.
- `ce_o` output 1: fetch enable; `pc_o` is meaningful only when this is 1.
- `pend_o` output 1: a branch is captured and waiting for the stall to release.
- `misalign_o` output 1: one-cycle pulse on a misaligned redirect; tied 0 without the macro.
- `bad_addr_o` output ADDR_W: last misaligned target; tied 0 without the macro.

## Operation
- States:
  - OFF: in reset, or the first cycle of reset.
  - RUN: normal fetch.
  - PEND: a branch is captured and stall is active.
- In reset: `ce_o`=0, `pc_o`=RESET_VEC, `pend_o`=0, pending target=0, `misalign_o`=0, `bad_addr_o`=0; state OFF.
- OFF to RUN: on the first clock edge with `rst`=0. At that edge `ce_o`←1 and `pc_o` stays RESET_VEC, so the reset vector is fetched first.
- In RUN and PEND, the next PC follows this priority:
  1. `flush_i`: `pc_o`←`flush_pc_i`. Taken even when `stall[0]`=1. Clears any pending target; state←RUN.
  2. `br_valid_i` with `stall[0]`=0: `pc_o`←`br_target_i`. Clears any pending target; state←RUN.
  3. `br_valid_i` with `stall[0]`=1: pending target←`br_target_i`; state←PEND; `pc_o` held. A newer branch overwrites an older pending target.
  4. In PEND with `stall[0]`=0 and no flush or branch: `pc_o`←pending target; state←RUN.
  5. In RUN with `stall[0]`=0: `pc_o`←`pc_o`+STEP, modulo 2^ADDR_W. For example, 32'hFFFF_FFFC+4 gives 32'h0.
  6. Otherwise `pc_o` is held.
- `pend_o` is 1 exactly when the state is PEND.
- `stall[STALL_W-1:1]` is ignored.
- Reset has precedence in every state. Asserting `rst` mid-PEND discards the pending target on that edge.

## Timing
- All outputs are registered.
- Redirect latency: a flush or unstalled branch sampled at edge N appears on `pc_o` after edge N; the target is fetched in cycle N+1.
- Captured branch: applied on the first edge where `stall[0]`=0. That edge loads the target and increments nothing.
- A flush and a branch in the same cycle: the flush wins and the branch is dropped.
- Stall released and a new branch in the same cycle: the new branch wins over the pending target.
- `misalign_o` is high for exactly the one cycle after the offending edge.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined:
  - A redirect target from any source whose low ALIGN_BITS bits are nonzero is not loaded; `pc_o`←TRAP_VEC.
  - `misalign_o` pulses, `bad_addr_o`←the raw target, and the pending target is cleared.
- `PC_MISALIGN_TRAP_EN` undefined:
  - The low ALIGN_BITS bits of every redirect target are forced to 0 before loading.
  - `misalign_o` and `bad_addr_o` are constant 0.

## Test plan
- Reset then release: `rst` 1 for 3 cycles, then 0, no stall → `ce_o`=0/`pc_o`=0 during reset; then `pc_o` sequence 0, 0, 4, 8 and `ce_o`=1 from the first cycle after release.
- Stall hold: `stall`=6'b000001 for 2 cycles at `pc_o`=8 → `pc_o` stays 8, then continues 12.
- Branch captured during stall:
  - Stimulus: `stall[0]`=1, `br_valid_i` with target 32'h100, then target 32'h200 the next cycle.
  - Response: `pend_o`=1 and `pc_o` held.
  - On release: `pc_o`=32'h200, `pend_o`=0.
- Flush priority: `flush_i`/32'h80 with `br_valid_i`/32'h100 while stalled → `pc_o`=32'h80, `pend_o`=0.
- Wrap and misalign:
  - `pc_o`=32'hFFFF_FFFC unstalled → next `pc_o`=0.
  - Branch to 32'h102: with the macro, `pc_o`=32'h4, `misalign_o` pulses for 1 cycle, `bad_addr_o`=32'h102.
  - Branch to 32'h102 without the macro: `pc_o`=32'h100.
- Reset mid-PEND: assert `rst` while `pend_o`=1 → `pend_o`=0, `pc_o`=RESET_VEC, and the pending target is never applied.
